// File: rtl/mp_dot_engine_if.sv
// Bus bundle for mp_dot_engine: launch controls, weight/input SRAM read
// ports, result SRAM write port and status outputs.
interface mp_dot_engine_if #(
    parameter int N_OUT = 10,
    parameter int AW    = 7,
    parameter int ACC_W = 24
);
    localparam int RES_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // launch controls
    logic                 start;
    logic                 split;
    logic [AW-1:0]        w_base;
    logic [AW-1:0]        in_base;
    logic [AW-1:0]        r_base;

    // weight SRAM read port
    logic [AW-1:0]        weight_addr;
    logic                 weight_we;
    logic [8*N_OUT-1:0]   weight_data;

    // input activation SRAM read port
    logic [AW-1:0]        input_addr;
    logic                 input_we;
    logic [7:0]           input_data;

    // result SRAM write port
    logic                 result_we;
    logic [AW-1:0]        result_addr;
    logic [ACC_W-1:0]     result_data;

    // status
    logic                 busy;
    logic                 done;
    logic [RES_W-1:0]     inference_result;

    // Host / memory side: drives launch controls and SRAM read data.
    modport master (
        output start, split, w_base, in_base, r_base,
        output weight_data, input_data,
        input  weight_addr, weight_we, input_addr, input_we,
        input  result_we, result_addr, result_data,
        input  busy, done, inference_result
    );

    // Engine side.
    modport slave (
        input  start, split, w_base, in_base, r_base,
        input  weight_data, input_data,
        output weight_addr, weight_we, input_addr, input_we,
        output result_we, result_addr, result_data,
        output busy, done, inference_result
    );
endinterface

// File: rtl/mp_dot_engine.sv
// Multi-precision dot-product engine: streams LEN taps of activation and
// weight rows from 1-cycle-latency SRAMs into N_OUT signed accumulators
// (one 8x8 product or two 4x4 products per tap), writes the accumulators
// out, and reports the argmax index.
module mp_dot_engine #(
    parameter int N_OUT = 10,
    parameter int LEN   = 100,
    parameter int AW    = 7,
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    mp_dot_engine_if.slave    bus
);
    localparam int RES_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CNT_MAX = (LEN > N_OUT) ? LEN : N_OUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     split_q, split_d;
    logic [AW-1:0]            r_base_q, r_base_d;
    logic [AW-1:0]            w_addr_q, w_addr_d;
    logic [AW-1:0]            in_addr_q, in_addr_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     done_q, done_d;
    logic [RES_W-1:0]         res_q, res_d;
    logic [RES_W-1:0]         best_idx_q, best_idx_d;
    logic signed [ACC_W-1:0]  best_val_q, best_val_d;
    logic signed [ACC_W-1:0]  acc_q [N_OUT];
    logic signed [ACC_W-1:0]  acc_d [N_OUT];
    logic signed [ACC_W-1:0]  prod  [N_OUT];
    logic [RES_W-1:0]         wr_idx;
    logic signed [ACC_W-1:0]  acc_sel;

    // One tap's contribution: unsigned activation times signed weight,
    // either as a single 8-bit pair or as two independent nibble pairs.
    function automatic logic signed [ACC_W-1:0] tap_product(
        input logic [7:0] act,
        input logic [7:0] w,
        input logic       dual
    );
        logic signed [16:0] p_full;
        logic signed [9:0]  p_lo;
        logic signed [9:0]  p_hi;
        p_full = 17'($signed({1'b0, act})) * 17'($signed(w));
        p_lo   = 10'($signed({1'b0, act[3:0]})) * 10'($signed(w[3:0]));
        p_hi   = 10'($signed({1'b0, act[7:4]})) * 10'($signed(w[7:4]));
        if (dual) begin
            return ACC_W'(p_lo + p_hi);
        end
        return ACC_W'(p_full);
    endfunction

    assign wr_idx  = cnt_q[RES_W-1:0];
    assign acc_sel = acc_q[wr_idx];

    // Sequencer: launch capture, tap/output counting and address stepping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        split_d   = split_q;
        r_base_d  = r_base_q;
        w_addr_d  = w_addr_q;
        in_addr_d = in_addr_q;
        done_d    = 1'b0;
        res_d     = res_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    split_d   = bus.split;
                    r_base_d  = bus.r_base;
                    w_addr_d  = bus.w_base;
                    in_addr_d = bus.in_base;
                end
            end
            RUN: begin
                if (cnt_q == LAST_TAP) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    w_addr_d  = w_addr_q + 1'b1;
                    in_addr_d = in_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = WRITE;
                cnt_d   = '0;
            end
            WRITE: begin
                if (cnt_q == LAST_OUT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                res_d   = best_idx_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-neuron tap products from the SRAM data currently on the bus.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            prod[j] = tap_product(bus.input_data, bus.weight_data[8*j +: 8], split_q);
        end
    end

    // Accumulators clear on launch and add one tap each time read data lands.
    always_comb begin
        rd_pend_d = (state_q == RUN);
        for (int j = 0; j < N_OUT; j++) begin
            acc_d[j] = acc_q[j];
            if ((state_q == IDLE) && bus.start) begin
                acc_d[j] = '0;
            end else if (rd_pend_q) begin
                acc_d[j] = acc_q[j] + prod[j];
            end
        end
    end

    // Running argmax as the accumulators stream out; strict compare keeps
    // the lowest index on ties.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (state_q == WRITE) begin
            if ((cnt_q == '0) || (acc_sel > best_val_q)) begin
                best_val_d = acc_sel;
                best_idx_d = wr_idx;
            end
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            split_q    <= 1'b0;
            r_base_q   <= '0;
            w_addr_q   <= '0;
            in_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            split_q    <= split_d;
            r_base_q   <= r_base_d;
            w_addr_q   <= w_addr_d;
            in_addr_q  <= in_addr_d;
            rd_pend_q  <= rd_pend_d;
            done_q     <= done_d;
            res_q      <= res_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign bus.weight_addr      = w_addr_q;
    assign bus.input_addr       = in_addr_q;
    assign bus.weight_we        = 1'b0;
    assign bus.input_we         = 1'b0;
    assign bus.busy             = (state_q != IDLE);
    assign bus.done             = done_q;
    assign bus.inference_result = res_q;
    assign bus.result_we        = (state_q == WRITE);
    assign bus.result_addr      = (state_q == WRITE) ? (r_base_q + AW'(cnt_q)) : '0;
    assign bus.result_data      = (state_q == WRITE) ? acc_sel : '0;
endmodule

// File: tb/tb_mp_dot_engine.sv
// Self-checking bench for mp_dot_engine with behavioural SRAM models and a
// plain-arithmetic reference model of the dot products and argmax.
module tb_mp_dot_engine;
    localparam int N_OUT = 10;
    localparam int LEN   = 4;
    localparam int AW    = 7;
    localparam int ACC_W = 24;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mp_dot_engine_if #(.N_OUT(N_OUT), .AW(AW), .ACC_W(ACC_W)) bus ();

    mp_dot_engine #(.N_OUT(N_OUT), .LEN(LEN), .AW(AW), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [8*N_OUT-1:0] wmem [DEPTH];
    logic [7:0]         imem [DEPTH];

    int testsRun;
    int testsFailed;
    logic [ACC_W-1:0] expAcc [N_OUT];
    int expIdx;
    int lastIdx;
    int curWb, curIb, curRb;
    logic curSplit;
    int holdWb, holdIb, holdRb;
    logic holdSplit;

    // Synchronous-read SRAMs: address seen at one edge, data available for the next.
    always @(posedge clk) begin
        bus.weight_data <= wmem[bus.weight_addr];
        bus.input_data  <= imem[bus.input_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        testsRun++;
        if (got !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    function automatic int sext8(input logic [7:0] v);
        return v[7] ? int'(v) - 256 : int'(v);
    endfunction

    function automatic int sext4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Reference dot products over the memory images, then argmax.
    task automatic computeModel(input logic sp, input int wb, input int ib);
        int bestVal;
        for (int j = 0; j < N_OUT; j++) begin
            longint sum;
            sum = 0;
            for (int k = 0; k < LEN; k++) begin
                int a;
                logic [7:0] w;
                a = int'(imem[(ib + k) % DEPTH]);
                w = wmem[(wb + k) % DEPTH][8*j +: 8];
                if (!sp) sum += longint'(a * sext8(w));
                else     sum += longint'((a % 16) * sext4(w[3:0]) + (a / 16) * sext4(w[7:4]));
            end
            expAcc[j] = sum[ACC_W-1:0];
        end
        expIdx  = 0;
        bestVal = 0;
        for (int j = 0; j < N_OUT; j++) begin
            int v;
            v = int'($signed(expAcc[j]));
            if (j == 0 || v > bestVal) begin
                bestVal = v;
                expIdx  = j;
            end
        end
    endtask

    task automatic setExpect(input logic sp, input int wb, input int ib, input int rb);
        curSplit = sp;
        curWb    = wb;
        curIb    = ib;
        curRb    = rb;
        computeModel(sp, wb, ib);
    endtask

    task automatic applyStimulus(input logic sp, input int wb, input int ib, input int rb);
        setExpect(sp, wb, ib, rb);
        bus.split   = sp;
        bus.w_base  = AW'(wb);
        bus.in_base = AW'(ib);
        bus.r_base  = AW'(rb);
        bus.start   = 1'b1;
    endtask

    task automatic checkResetState(input string prefix);
        checkOutput({prefix, "_busy"},        64'(bus.busy), 64'd0);
        checkOutput({prefix, "_done"},        64'(bus.done), 64'd0);
        checkOutput({prefix, "_result_we"},   64'(bus.result_we), 64'd0);
        checkOutput({prefix, "_weight_addr"}, 64'(bus.weight_addr), 64'd0);
        checkOutput({prefix, "_input_addr"},  64'(bus.input_addr), 64'd0);
        checkOutput({prefix, "_result_addr"}, 64'(bus.result_addr), 64'd0);
        checkOutput({prefix, "_result_data"}, 64'(bus.result_data), 64'd0);
        checkOutput({prefix, "_inference"},   64'(bus.inference_result), 64'd0);
    endtask

    // Follows one inference from its start edge to the done pulse; with
    // holdStart, start is raised mid-run with scrambled launch values and left high.
    task automatic observeRun(input bit holdStart);
        int doneEdge;
        int wrCount;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        doneEdge  = -1;
        wrCount   = 0;
        checkOutput("result_held_at_launch", 64'(bus.inference_result), 64'(lastIdx));
        checkOutput("done_low_at_launch", 64'(bus.done), 64'd0);
        for (int n = 0; n < 100; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (n < LEN) begin
                checkOutput("weight_addr", 64'(bus.weight_addr), 64'((curWb + n) % DEPTH));
                checkOutput("input_addr", 64'(bus.input_addr), 64'((curIb + n) % DEPTH));
            end
            if (n == 0 || n == LEN + N_OUT + 1) begin
                checkOutput("busy_in_run", 64'(bus.busy), 64'd1);
            end
            if (holdStart && n == 2) begin
                holdSplit   = ~curSplit;
                holdWb      = int'($urandom_range(0, DEPTH - 1));
                holdIb      = int'($urandom_range(0, DEPTH - 1));
                holdRb      = int'($urandom_range(0, DEPTH - 1));
                bus.split   = holdSplit;
                bus.w_base  = AW'(holdWb);
                bus.in_base = AW'(holdIb);
                bus.r_base  = AW'(holdRb);
                bus.start   = 1'b1;
            end
            if (bus.result_we === 1'b1) begin
                if (wrCount < N_OUT) begin
                    checkOutput("write_cycle", 64'(n), 64'(LEN + 1 + wrCount));
                    checkOutput("write_addr", 64'(bus.result_addr), 64'((curRb + wrCount) % DEPTH));
                    checkOutput("write_data", 64'(bus.result_data), 64'(expAcc[wrCount]));
                end
                wrCount++;
            end
            if (bus.done === 1'b1) begin
                doneEdge = n;
                break;
            end
        end
        checkOutput("done_edge", 64'(doneEdge), 64'(LEN + N_OUT + 2));
        checkOutput("write_count", 64'(wrCount), 64'(N_OUT));
        if (doneEdge >= 0) begin
            checkOutput("busy_at_done", 64'(bus.busy), 64'd0);
            checkOutput("argmax", 64'(bus.inference_result), 64'(expIdx));
        end
        lastIdx = expIdx;
        if (!holdStart) begin
            @(posedge clk);
            #1;
            checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
            checkOutput("idle_busy", 64'(bus.busy), 64'd0);
        end
    endtask

    // Asynchronous reset asserted in RUN cycle 2, then released cleanly.
    task automatic resetMidRun();
        applyStimulus(1'b0, 5, 90, 100);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("midrun_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("no_done_in_reset", 64'(bus.done), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("no_done_after_reset", 64'(bus.done), 64'd0);
        lastIdx = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        lastIdx     = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.split   = 1'b0;
        bus.w_base  = '0;
        bus.in_base = '0;
        bus.r_base  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            imem[i] = 8'($urandom);
            for (int j = 0; j < N_OUT; j++) begin
                wmem[i][8*j +: 8] = 8'($urandom);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checkResetState("power_on");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp inputs 1..4 against weight field j = j: acc[j] = 10*j, argmax 9.
        for (int k = 0; k < LEN; k++) begin
            imem[20 + k] = 8'(k + 1);
            for (int j = 0; j < N_OUT; j++) begin
                wmem[10 + k][8*j +: 8] = 8'(j);
            end
        end
        applyStimulus(1'b0, 10, 20, 30);
        observeRun(1'b0);

        resetMidRun();
        applyStimulus(1'b0, 10, 20, 30);
        observeRun(1'b0);

        // Dual-nibble mode: 0x21 against 0x3F gives 1*(-1) + 2*3 on neuron 0.
        imem[40] = 8'h21;
        imem[41] = 8'h00;
        imem[42] = 8'h00;
        imem[43] = 8'h00;
        wmem[50][7:0] = 8'h3F;
        applyStimulus(1'b1, 50, 40, 60);
        observeRun(1'b0);

        // Most negative weights with full-scale inputs: all neurons tie.
        for (int k = 0; k < LEN; k++) begin
            imem[70 + k] = 8'hFF;
            for (int j = 0; j < N_OUT; j++) begin
                wmem[60 + k][8*j +: 8] = 8'h80;
            end
        end
        applyStimulus(1'b0, 60, 70, 80);
        observeRun(1'b0);

        // Address wrap on all three ports.
        applyStimulus(1'b0, 126, 125, 127);
        observeRun(1'b0);

        // Start pulsed while busy and held through DONE: one relaunch after IDLE.
        applyStimulus(1'b1, 30, 50, 10);
        observeRun(1'b1);
        setExpect(holdSplit, holdWb, holdIb, holdRb);
        observeRun(1'b0);

        // Randomised launches in both modes.
        repeat (6) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, DEPTH - 1)));
            observeRun(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
